alu_reservation_station: RTL and testbench
==========================================

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: DEPTH, 4, number of entries (2..8).
REQ-003 Parameter: TAG_W, 4, tag width; tag value 0 is INVALID.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 ISSUE_VALID  in  1  issue request; ISSUE_READY  out  1  free entry available.
REQ-007 ISSUE_OP  in  4  ALU opcode; ISSUE_DEST_TAG  in  TAG_W  tag this result will broadcast under.
REQ-008 ISSUE_SRC1_TAG, ISSUE_SRC2_TAG  in  TAG_W  producer tag; 0 means the value field is valid.
REQ-009 ISSUE_SRC1_VAL, ISSUE_SRC2_VAL  in  32  operand value, meaningful only when its tag is 0.
REQ-010 CDB_TAG  in  TAG_W  broadcast tag, 0 = no broadcast; CDB_DATA  in  32  broadcast value.
REQ-011 DISP_VALID  out  1  ready entry offered; DISP_READY  in  1  ALU accepts.
REQ-012 DISP_OP  out  4; DISP_A, DISP_B  out  32; DISP_TAG  out  TAG_W  dispatched operation fields.
REQ-013 OCCUPANCY  out  4  number of non-FREE entries.

Function
REQ-014 Each entry SHALL hold state FREE, WAITING or READY, plus op, dest tag, two tag/value operand pairs.
REQ-015 Issue SHALL occur when ISSUE_VALID && ISSUE_READY, writing the lowest-index FREE entry.
REQ-016 ISSUE_READY SHALL equal (OCCUPANCY < DEPTH), using registered occupancy only; a same-cycle dispatch does not free a slot for issue.
REQ-017 At issue, an operand tag that equals a nonzero CDB_TAG SHALL capture CDB_DATA and store tag 0.
REQ-018 Issued entry SHALL enter READY if both stored tags are 0, otherwise WAITING.
REQ-019 Every cycle, each WAITING entry operand whose tag equals a nonzero CDB_TAG SHALL capture CDB_DATA and clear its tag to 0; both operands may match the same broadcast.
REQ-020 WAITING SHALL move to READY on the edge where its last pending tag clears.
REQ-021 DISP_VALID SHALL be high when any entry is eligible; the lowest-index eligible entry is presented.
REQ-022 DISP_* fields SHALL be driven combinationally from the selected entry and SHALL be 0 when DISP_VALID is low.
REQ-023 On DISP_VALID && DISP_READY, the selected entry SHALL become FREE at the next edge.
REQ-024 DISP_VALID low with DISP_READY high SHALL have no effect; DISP_VALID SHALL not drop without handshake except on reset.
REQ-025 Issue and dispatch in the same cycle SHALL both complete; OCCUPANCY stays unchanged.
REQ-026 Minimum latency: issue with both operands valid at edge N -> DISP_VALID high in cycle after edge N.
REQ-027 OCCUPANCY SHALL update each edge as +1 on issue, -1 on dispatch, saturating correctly at 0 and DEPTH.

Reset
REQ-028 RST high at an edge SHALL set all entries FREE and clear stored fields to 0, overriding issue, dispatch and CDB capture in that cycle.
REQ-029 After reset: ISSUE_READY=1, DISP_VALID=0, DISP_OP/A/B/TAG=0, OCCUPANCY=0.

Configuration
REQ-030 Macro RS_WAKEUP_BYPASS_EN, when defined, SHALL make a WAITING entry whose final pending tag matches current CDB_TAG eligible for dispatch in that same cycle, with CDB_DATA driven on the matching DISP_A/DISP_B.
REQ-031 Without RS_WAKEUP_BYPASS_EN, only READY entries SHALL be eligible; wakeup-to-dispatch is one cycle.
REQ-032 A bypassed entry accepted by DISP_READY SHALL go WAITING -> FREE directly; if not accepted it goes READY with captured data.

Verification
REQ-033 Reset, then issue op=3, tags 0/0, vals 5/7, dest 2 -> next cycle DISP_VALID=1, A=5, B=7, TAG=2; DISP_READY=1 -> OCCUPANCY back to 0.
REQ-034 Issue src1 tag 6, src2 tag 0 val 9; two cycles later CDB_TAG=6 DATA=0x1234 -> DISP_A=0x1234, B=9 next cycle (same cycle if RS_WAKEUP_BYPASS_EN).
REQ-035 Fill 4 entries with tag-5 dependencies -> ISSUE_READY=0; issue attempt ignored; CDB_TAG=5 -> entries dispatched in index order 0,1,2,3.
REQ-036 Issue src1/src2 tag 7 while CDB_TAG=7 DATA=0xAA same cycle -> entry READY, A=B=0xAA.
REQ-037 Full RS, DISP_READY=1 and ISSUE_VALID=1 same cycle -> issue rejected, OCCUPANCY=3; RST asserted mid-operation -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station.
//
// Holds up to DEPTH issued ALU operations until both source operands are
// available, captures operands from the common data bus (CDB), and offers the
// lowest-index ready operation to the ALU through a valid/ready handshake.
//
// Build option:
//   RS_WAKEUP_BYPASS_EN - when defined, a WAITING entry whose last pending
//   operand tag matches the current CDB_TAG can be dispatched in the same
//   cycle. CDB_DATA is forwarded straight onto DISP_A/DISP_B. When it is
//   undefined, only READY entries can be dispatched, so a wakeup reaches the
//   ALU one cycle later.
//
// Ports:
//   CLK, RST                    clock; synchronous active-high reset
//   ISSUE_VALID / ISSUE_READY   issue handshake. Ready while an entry is free
//   ISSUE_OP, ISSUE_DEST_TAG    opcode and the tag the result broadcasts under
//   ISSUE_SRC{1,2}_TAG/_VAL     producer tag (0 = value valid) and value
//   CDB_TAG, CDB_DATA           result broadcast (tag 0 = no broadcast)
//   DISP_VALID / DISP_READY     dispatch handshake towards the ALU
//   DISP_OP, DISP_A, DISP_B,
//   DISP_TAG                    selected operation. All zero when not valid
//   OCCUPANCY                   number of occupied entries (registered)
module alu_reservation_station #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  // Issue side
  input  logic             ISSUE_VALID,
  output logic             ISSUE_READY,
  input  logic [3:0]       ISSUE_OP,
  input  logic [TAG_W-1:0] ISSUE_DEST_TAG,
  input  logic [TAG_W-1:0] ISSUE_SRC1_TAG,
  input  logic [TAG_W-1:0] ISSUE_SRC2_TAG,
  input  logic [31:0]      ISSUE_SRC1_VAL,
  input  logic [31:0]      ISSUE_SRC2_VAL,
  // Result broadcast
  input  logic [TAG_W-1:0] CDB_TAG,
  input  logic [31:0]      CDB_DATA,
  // Dispatch side
  output logic             DISP_VALID,
  input  logic             DISP_READY,
  output logic [3:0]       DISP_OP,
  output logic [31:0]      DISP_A,
  output logic [31:0]      DISP_B,
  output logic [TAG_W-1:0] DISP_TAG,
  output logic [3:0]       OCCUPANCY
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    StFree    = 2'd0,
    StWaiting = 2'd1,
    StReady   = 2'd2
  } ent_state_e;

  // Entry storage
  ent_state_e       state_q [DEPTH];
  ent_state_e       state_d [DEPTH];
  logic [3:0]       op_q    [DEPTH];
  logic [3:0]       op_d    [DEPTH];
  logic [TAG_W-1:0] dest_q  [DEPTH];
  logic [TAG_W-1:0] dest_d  [DEPTH];
  logic [TAG_W-1:0] tag1_q  [DEPTH];
  logic [TAG_W-1:0] tag1_d  [DEPTH];
  logic [TAG_W-1:0] tag2_q  [DEPTH];
  logic [TAG_W-1:0] tag2_d  [DEPTH];
  logic [31:0]      val1_q  [DEPTH];
  logic [31:0]      val1_d  [DEPTH];
  logic [31:0]      val2_q  [DEPTH];
  logic [31:0]      val2_d  [DEPTH];

  logic [3:0]       occ_q;
  logic [3:0]       occ_d;

  // Control
  logic             cdb_hit;
  logic             issue_fire;
  logic             issue_found;
  logic [IdxW-1:0]  issue_idx;
  logic [DEPTH-1:0] wake1;
  logic [DEPTH-1:0] wake2;
  logic [DEPTH-1:0] elig;
  logic             disp_valid;
  logic [IdxW-1:0]  disp_idx;
  logic             disp_fire;
  logic [TAG_W-1:0] new_tag1;
  logic [TAG_W-1:0] new_tag2;
  logic [31:0]      new_val1;
  logic [31:0]      new_val2;

  assign cdb_hit = (CDB_TAG != '0);

  // Only registered occupancy gates issue, so a slot freed by a dispatch in the
  // same cycle cannot be reused until the next cycle.
  assign ISSUE_READY = (32'(occ_q) < DEPTH);
  assign issue_fire  = ISSUE_VALID && ISSUE_READY;
  assign OCCUPANCY   = occ_q;

  // Lowest-index free entry
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!issue_found && (state_q[i] == StFree)) begin
        issue_found = 1'b1;
        issue_idx   = IdxW'(i);
      end
    end
  end

  // Per-entry wakeup matches and dispatch eligibility
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    elig  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = cdb_hit && (state_q[i] == StWaiting) && (tag1_q[i] == CDB_TAG);
      wake2[i] = cdb_hit && (state_q[i] == StWaiting) && (tag2_q[i] == CDB_TAG);
`ifdef RS_WAKEUP_BYPASS_EN
      // A waiting entry is eligible once the broadcast clears every pending tag.
      elig[i]  = (state_q[i] == StReady) ||
                 ((state_q[i] == StWaiting) &&
                  ((tag1_q[i] == '0) || wake1[i]) &&
                  ((tag2_q[i] == '0) || wake2[i]));
`else
      elig[i]  = (state_q[i] == StReady);
`endif
    end
  end

  // Lowest-index eligible entry
  always_comb begin
    disp_valid = 1'b0;
    disp_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!disp_valid && elig[i]) begin
        disp_valid = 1'b1;
        disp_idx   = IdxW'(i);
      end
    end
  end

  assign disp_fire = disp_valid && DISP_READY;

  // Dispatch outputs, forced to zero when nothing is offered
  always_comb begin
    DISP_VALID = disp_valid;
    DISP_OP    = '0;
    DISP_A     = '0;
    DISP_B     = '0;
    DISP_TAG   = '0;
    if (disp_valid) begin
      DISP_OP  = op_q[disp_idx];
      DISP_TAG = dest_q[disp_idx];
`ifdef RS_WAKEUP_BYPASS_EN
      DISP_A   = wake1[disp_idx] ? CDB_DATA : val1_q[disp_idx];
      DISP_B   = wake2[disp_idx] ? CDB_DATA : val2_q[disp_idx];
`else
      DISP_A   = val1_q[disp_idx];
      DISP_B   = val2_q[disp_idx];
`endif
    end
  end

  // Incoming operands, with capture of a broadcast in the same cycle
  always_comb begin
    new_tag1 = ISSUE_SRC1_TAG;
    new_val1 = ISSUE_SRC1_VAL;
    new_tag2 = ISSUE_SRC2_TAG;
    new_val2 = ISSUE_SRC2_VAL;
    if (cdb_hit && (ISSUE_SRC1_TAG == CDB_TAG)) begin
      new_tag1 = '0;
      new_val1 = CDB_DATA;
    end
    if (cdb_hit && (ISSUE_SRC2_TAG == CDB_TAG)) begin
      new_tag2 = '0;
      new_val2 = CDB_DATA;
    end
  end

  // Entry next state: wakeup, then dispatch, then issue into a free slot.
  // Dispatch and issue never target the same entry, because issue only writes
  // FREE entries and dispatch only selects occupied ones.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      dest_d[i]  = dest_q[i];
      tag1_d[i]  = tag1_q[i];
      tag2_d[i]  = tag2_q[i];
      val1_d[i]  = val1_q[i];
      val2_d[i]  = val2_q[i];

      if (wake1[i]) begin
        tag1_d[i] = '0;
        val1_d[i] = CDB_DATA;
      end
      if (wake2[i]) begin
        tag2_d[i] = '0;
        val2_d[i] = CDB_DATA;
      end
      if ((state_q[i] == StWaiting) &&
          ((tag1_q[i] == '0) || wake1[i]) &&
          ((tag2_q[i] == '0) || wake2[i])) begin
        state_d[i] = StReady;
      end

      // A bypassed entry that is accepted goes straight from WAITING to FREE.
      if (disp_fire && (disp_idx == IdxW'(i))) begin
        state_d[i] = StFree;
      end

      if (issue_fire && (issue_idx == IdxW'(i))) begin
        op_d[i]    = ISSUE_OP;
        dest_d[i]  = ISSUE_DEST_TAG;
        tag1_d[i]  = new_tag1;
        tag2_d[i]  = new_tag2;
        val1_d[i]  = new_val1;
        val2_d[i]  = new_val2;
        state_d[i] = ((new_tag1 == '0) && (new_tag2 == '0)) ? StReady : StWaiting;
      end
    end
  end

  // Occupancy: +1 on issue, -1 on dispatch, unchanged when both happen
  always_comb begin
    occ_d = occ_q;
    unique case ({issue_fire, disp_fire})
      2'b10: if (32'(occ_q) < DEPTH) occ_d = occ_q + 4'd1;
      2'b01: if (occ_q != 4'd0) occ_d = occ_q - 4'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= StFree;
        op_q[i]    <= '0;
        dest_q[i]  <= '0;
        tag1_q[i]  <= '0;
        tag2_q[i]  <= '0;
        val1_q[i]  <= '0;
        val2_q[i]  <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        dest_q[i]  <= dest_d[i];
        tag1_q[i]  <= tag1_d[i];
        tag2_q[i]  <= tag2_d[i];
        val1_q[i]  <= val1_d[i];
        val2_q[i]  <= val2_d[i];
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed, table-driven bench for alu_reservation_station (DEPTH=4, TAG_W=4).
// Inputs change on the falling edge. Outputs are compared 1 ns later, which
// shows the state left by the previous rising edge together with this cycle's
// inputs.
module tb_alu_reservation_station;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ISSUE_VALID;
  logic        ISSUE_READY;
  logic [3:0]  ISSUE_OP;
  logic [3:0]  ISSUE_DEST_TAG;
  logic [3:0]  ISSUE_SRC1_TAG;
  logic [3:0]  ISSUE_SRC2_TAG;
  logic [31:0] ISSUE_SRC1_VAL;
  logic [31:0] ISSUE_SRC2_VAL;
  logic [3:0]  CDB_TAG;
  logic [31:0] CDB_DATA;
  logic        DISP_VALID;
  logic        DISP_READY;
  logic [3:0]  DISP_OP;
  logic [31:0] DISP_A;
  logic [31:0] DISP_B;
  logic [3:0]  DISP_TAG;
  logic [3:0]  OCCUPANCY;

  alu_reservation_station #(
    .DEPTH(4),
    .TAG_W(4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ISSUE_VALID   (ISSUE_VALID),
    .ISSUE_READY   (ISSUE_READY),
    .ISSUE_OP      (ISSUE_OP),
    .ISSUE_DEST_TAG(ISSUE_DEST_TAG),
    .ISSUE_SRC1_TAG(ISSUE_SRC1_TAG),
    .ISSUE_SRC2_TAG(ISSUE_SRC2_TAG),
    .ISSUE_SRC1_VAL(ISSUE_SRC1_VAL),
    .ISSUE_SRC2_VAL(ISSUE_SRC2_VAL),
    .CDB_TAG       (CDB_TAG),
    .CDB_DATA      (CDB_DATA),
    .DISP_VALID    (DISP_VALID),
    .DISP_READY    (DISP_READY),
    .DISP_OP       (DISP_OP),
    .DISP_A        (DISP_A),
    .DISP_B        (DISP_B),
    .DISP_TAG      (DISP_TAG),
    .OCCUPANCY     (OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic [3:0]  t2;
    logic [31:0] v2;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        dr;
    logic        e_ir;
    logic        e_dv;
    logic [3:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [3:0]  e_tag;
    logic [3:0]  e_occ;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic [3:0] op, input logic [3:0] dest,
    input logic [3:0] t1, input logic [31:0] v1, input logic [3:0] t2, input logic [31:0] v2,
    input logic [3:0] ct, input logic [31:0] cd, input logic dr,
    input logic e_ir, input logic e_dv, input logic [3:0] e_op, input logic [31:0] e_a,
    input logic [31:0] e_b, input logic [3:0] e_tag, input logic [3:0] e_occ);
    vec_t v;
    v.rst = rst;   v.iv = iv;     v.op = op;     v.dest = dest;
    v.t1 = t1;     v.v1 = v1;     v.t2 = t2;     v.v2 = v2;
    v.ct = ct;     v.cd = cd;     v.dr = dr;
    v.e_ir = e_ir; v.e_dv = e_dv; v.e_op = e_op; v.e_a = e_a;
    v.e_b = e_b;   v.e_tag = e_tag; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge CLK);
    RST            = v.rst;
    ISSUE_VALID    = v.iv;
    ISSUE_OP       = v.op;
    ISSUE_DEST_TAG = v.dest;
    ISSUE_SRC1_TAG = v.t1;
    ISSUE_SRC1_VAL = v.v1;
    ISSUE_SRC2_TAG = v.t2;
    ISSUE_SRC2_VAL = v.v2;
    CDB_TAG        = v.ct;
    CDB_DATA       = v.cd;
    DISP_READY     = v.dr;
    #1;
    chk({nm, ".issue_ready"}, 32'(ISSUE_READY), 32'(v.e_ir));
    chk({nm, ".disp_valid"},  32'(DISP_VALID),  32'(v.e_dv));
    chk({nm, ".disp_op"},     32'(DISP_OP),     32'(v.e_op));
    chk({nm, ".disp_a"},      DISP_A,           v.e_a);
    chk({nm, ".disp_b"},      DISP_B,           v.e_b);
    chk({nm, ".disp_tag"},    32'(DISP_TAG),    32'(v.e_tag));
    chk({nm, ".occupancy"},   32'(OCCUPANCY),   32'(v.e_occ));
  endtask

  vec_t tbl [24];
  vec_t v;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Inputs quiet, reset held for two edges
    RST = 1'b1; ISSUE_VALID = 1'b0; ISSUE_OP = '0; ISSUE_DEST_TAG = '0;
    ISSUE_SRC1_TAG = '0; ISSUE_SRC2_TAG = '0; ISSUE_SRC1_VAL = '0; ISSUE_SRC2_VAL = '0;
    CDB_TAG = '0; CDB_DATA = '0; DISP_READY = 1'b0;
    repeat (2) @(posedge CLK);

    //             rst iv op dest t1 v1       t2 v2     ct cd      dr   ir dv op a      b      tag occ
    // Reset values, then the basic ready-at-issue path
    tbl[0]  = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    tbl[1]  = mk(0, 1, 3, 2,  0, 5,      0, 7,     0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    tbl[2]  = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     1,   1, 1, 3, 5,     7,     2, 1);
    tbl[3]  = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    // Both sources captured from a broadcast in the issue cycle
    tbl[4]  = mk(0, 1, 1, 3,  7, 'h11,   7, 'h22,  7, 'hAA,  0,   1, 0, 0, 0,     0,     0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     1,   1, 1, 1, 'hAA,  'hAA,  3, 1);
    tbl[6]  = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    // Fill with ready entries, then issue+dispatch while full: the issue is rejected
    tbl[7]  = mk(0, 1, 4, 1,  0, 'h10,   0, 'h20,  0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    tbl[8]  = mk(0, 1, 5, 2,  0, 'h11,   0, 'h21,  0, 0,     0,   1, 1, 4, 'h10,  'h20,  1, 1);
    tbl[9]  = mk(0, 1, 6, 3,  0, 'h12,   0, 'h22,  0, 0,     0,   1, 1, 4, 'h10,  'h20,  1, 2);
    tbl[10] = mk(0, 1, 7, 4,  0, 'h13,   0, 'h23,  0, 0,     0,   1, 1, 4, 'h10,  'h20,  1, 3);
    tbl[11] = mk(0, 1, 8, 5,  0, 'h14,   0, 'h24,  0, 0,     1,   0, 1, 4, 'h10,  'h20,  1, 4);
    tbl[12] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     0,   1, 1, 5, 'h11,  'h21,  2, 3);
    tbl[13] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     1,   1, 1, 5, 'h11,  'h21,  2, 3);
    tbl[14] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     1,   1, 1, 6, 'h12,  'h22,  3, 2);
    tbl[15] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     1,   1, 1, 7, 'h13,  'h23,  4, 1);
    // DISP_READY with nothing valid has no effect; the rejected op 8 never appears
    tbl[16] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     1,   1, 0, 0, 0,     0,     0, 0);
    tbl[17] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    // Fill with entries waiting on tag 5; a fifth issue while full is ignored
    tbl[18] = mk(0, 1, 9, 9,  5, 'hBAD,  0, 100,   0, 0,     0,   1, 0, 0, 0,     0,     0, 0);
    tbl[19] = mk(0, 1, 10, 10, 5, 'hBAD, 0, 101,   0, 0,     0,   1, 0, 0, 0,     0,     0, 1);
    tbl[20] = mk(0, 1, 11, 11, 5, 'hBAD, 0, 102,   0, 0,     0,   1, 0, 0, 0,     0,     0, 2);
    tbl[21] = mk(0, 1, 12, 12, 5, 'hBAD, 0, 103,   0, 0,     0,   1, 0, 0, 0,     0,     0, 3);
    tbl[22] = mk(0, 1, 13, 13, 0, 1,     0, 2,     0, 0,     1,   0, 0, 0, 0,     0,     0, 4);
    tbl[23] = mk(0, 0, 0, 0,  0, 0,      0, 0,     0, 0,     0,   0, 0, 0, 0,     0,     0, 4);

    for (int i = 0; i < 24; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Broadcast tag 5 wakes all four; they then leave in index order 0..3
`ifdef RS_WAKEUP_BYPASS_EN
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 'h55, 0,  0, 1, 9, 'h55, 100, 9, 4);
`else
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 'h55, 0,  0, 0, 0, 0, 0, 0, 4);
`endif
    run_vec(v, "wake5");
    for (int k = 0; k < 4; k++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
             (k != 0), 1, 4'(9 + k), 'h55, 32'(100 + k), 4'(9 + k), 4'(4 - k));
      run_vec(v, $sformatf("drain%0d", k));
    end
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0), "drained");

    // Source 1 waits on tag 6; the broadcast comes two cycles after issue
    run_vec(mk(0, 1, 2, 4, 6, 'hDEAD, 0, 9, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0), "w6_issue");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1), "w6_wait");
`ifdef RS_WAKEUP_BYPASS_EN
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 'h1234, 0,  1, 1, 2, 'h1234, 9, 4, 1);
`else
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 'h1234, 0,  1, 0, 0, 0, 0, 0, 1);
`endif
    run_vec(v, "w6_cdb");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 'h1234, 9, 4, 1), "w6_ready");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 2, 'h1234, 9, 4, 1), "w6_disp");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0), "w6_done");

    // Reset in the middle of activity overrides issue, dispatch and capture
    run_vec(mk(0, 1, 1, 1, 0, 1, 0, 2, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0), "r_issue0");
    run_vec(mk(0, 1, 2, 2, 3, 0, 0, 4, 0, 0, 0,  1, 1, 1, 1, 2, 1, 1), "r_issue1");
    run_vec(mk(1, 1, 3, 3, 0, 5, 0, 6, 3, 'h77, 1,  1, 1, 1, 1, 2, 1, 2), "r_assert");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0), "r_after");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 'h77, 0,  1, 0, 0, 0, 0, 0, 0), "r_cdb3");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0), "r_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
